// File: rtl/div_seq.sv
// rtl/div_seq.sv - multi-cycle radix-2 restoring divider sequencer for MIPS DIV/DIVU
module div_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  signed_div,
  input  logic [DATA_W-1:0]     opdata1,
  input  logic [DATA_W-1:0]     opdata2,
  input  logic                  annul,
  output logic [2*DATA_W-1:0]   result,
  output logic                  ready,
  output logic                  stallreq
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   dvd;       // dividend magnitude, consumed MSB first by left shifts
  logic [DATA_W-1:0]   dvs;       // divisor magnitude
  logic [DATA_W-1:0]   rem;       // partial remainder
  logic [DATA_W-1:0]   quot;      // quotient bits collected so far
  logic                neg_quot;  // operand signs differ on a signed divide
  logic                neg_rem;   // negative dividend on a signed divide

  logic [DATA_W-1:0]   abs_op1;
  logic [DATA_W-1:0]   abs_op2;
  logic [DATA_W:0]     trial;
  logic [DATA_W:0]     diff;
  logic                q_bit;
  logic [DATA_W-1:0]   rem_nxt;
  logic [DATA_W-1:0]   quot_nxt;
  logic [DATA_W-1:0]   rem_fix;
  logic [DATA_W-1:0]   quot_fix;

  // Operand magnitudes and one shift-subtract step plus the final sign fixup
  always_comb begin
    abs_op1  = opdata1;
    abs_op2  = opdata2;
    trial    = '0;
    diff     = '0;
    q_bit    = 1'b0;
    rem_nxt  = '0;
    quot_nxt = '0;
    rem_fix  = '0;
    quot_fix = '0;

    if (signed_div && opdata1[DATA_W-1]) begin
      abs_op1 = -opdata1;
    end
    if (signed_div && opdata2[DATA_W-1]) begin
      abs_op2 = -opdata2;
    end

    // The shifted remainder needs one extra bit: 2*rem+1 can exceed DATA_W bits
    trial    = {rem, dvd[DATA_W-1]};
    diff     = trial - {1'b0, dvs};
    q_bit    = ~diff[DATA_W];
    rem_nxt  = q_bit ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
    quot_nxt = {quot[DATA_W-2:0], q_bit};

    // -2^31 / -1 falls out naturally: magnitude 0x80000000, no negation
    quot_fix = neg_quot ? -quot_nxt : quot_nxt;
    rem_fix  = neg_rem  ? -rem_nxt  : rem_nxt;
  end

  // Stall while a divide is being accepted or computed; END releases the pipeline
  assign stallreq = ((state == S_IDLE) && start && !annul)
                  || (state == S_ON)
                  || (state == S_DIVZERO);

  // Sequencer: operand capture, iteration, and registered result/ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      quot     <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      result   <= '0;
      ready    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          result <= '0;
          ready  <= 1'b0;
          if (start && !annul) begin
            dvd      <= abs_op1;
            dvs      <= abs_op2;
            rem      <= '0;
            quot     <= '0;
            cnt      <= '0;
            neg_quot <= signed_div && (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
            neg_rem  <= signed_div && opdata1[DATA_W-1];
            if (opdata2 == '0) begin
              state <= S_DIVZERO;
            end else begin
              state <= S_ON;
            end
          end
        end

        S_ON: begin
          if (annul) begin
            state  <= S_IDLE;
            cnt    <= '0;
            result <= '0;
            ready  <= 1'b0;
          end else begin
            rem  <= rem_nxt;
            quot <= quot_nxt;
            dvd  <= {dvd[DATA_W-2:0], 1'b0};
            cnt  <= cnt + CNT_W'(1);
            if (cnt == LAST_CNT) begin
              state  <= S_END;
              result <= {rem_fix, quot_fix};
              ready  <= 1'b1;
            end
          end
        end

        S_DIVZERO: begin
          if (annul) begin
            state  <= S_IDLE;
            result <= '0;
            ready  <= 1'b0;
          end else begin
            state  <= S_END;
            result <= '0;
            ready  <= 1'b1;
          end
        end

        S_END: begin
          // EX keeps start high while stalled elsewhere; hold the result until it lets go
          if (annul || !start) begin
            state  <= S_IDLE;
            result <= '0;
            ready  <= 1'b0;
          end
        end

        default: begin
          state  <= S_IDLE;
          result <= '0;
          ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - self-checking bench for div_seq
module tb_div_seq;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           signed_div;
  logic [W-1:0]   opdata1;
  logic [W-1:0]   opdata2;
  logic           annul;
  logic [2*W-1:0] result;
  logic           ready;
  logic           stallreq;

  always #5 clk = ~clk;

  div_seq #(.DATA_W(W), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .result     (result),
    .ready      (ready),
    .stallreq   (stallreq)
  );

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] sb_q[$];

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2*W-1:0] exp;
    int           lat;
    logic         hold;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic launch(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    signed_div = sgn;
    opdata1    = a;
    opdata2    = b;
    annul      = 1'b0;
    start      = 1'b1;
  endtask

  // Called in cycle 0 (IDLE with start seen); follows the divide to completion and release
  task automatic wait_done(input int lat, input logic hold);
    int c = 0;
    logic stall_ok = 1'b1;
    logic [2*W-1:0] exp = '0;
    #1;
    check("stallreq_cycle0", {63'b0, stallreq}, 64'd1);
    while (c < 40) begin
      @(negedge clk);
      c++;
      if (ready === 1'b1) break;
      if (stallreq !== 1'b1) stall_ok = 1'b0;
    end
    check("latency", 64'(c), 64'(lat));
    check("stall_window", {63'b0, stall_ok}, 64'd1);
    check("stallreq_in_end", {63'b0, stallreq}, 64'd0);
    if (sb_q.size() == 0) begin
      check("scoreboard_nonempty", 64'd0, 64'd1);
    end else begin
      exp = sb_q.pop_front();
    end
    check("result", result, exp);
    if (hold) begin
      @(negedge clk);
      check("hold_ready", {63'b0, ready}, 64'd1);
      check("hold_result", result, exp);
    end
    start = 1'b0;
    @(negedge clk);
    check("idle_ready", {63'b0, ready}, 64'd0);
    check("idle_result", result, 64'd0);
    check("idle_stallreq", {63'b0, stallreq}, 64'd0);
  endtask

  function automatic logic [2*W-1:0] model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (b == 0) return '0;
    if (sgn) begin
      q = W'($signed(a) / $signed(b));
      r = W'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  initial begin
    logic saw_ready;
    tbl[0] = '{1'b0, 32'd7,        32'd2,        {32'h1, 32'h3},               33, 1'b1};
    tbl[1] = '{1'b1, 32'hFFFFFFF9, 32'h2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 1'b0};
    tbl[2] = '{1'b1, 32'd7,        32'hFFFFFFFE, {32'h1, 32'hFFFFFFFD},        33, 1'b0};
    tbl[3] = '{1'b0, 32'hFFFFFFF9, 32'h2,        {32'h1, 32'h7FFFFFFC},        33, 1'b0};
    tbl[4] = '{1'b1, 32'd5,        32'd0,        64'd0,                        2,  1'b1};
    tbl[5] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000},        33, 1'b0};
    tbl[6] = '{1'b0, 32'd0,        32'd5,        64'd0,                        33, 1'b0};
    tbl[7] = '{1'b0, 32'hFFFFFFFF, 32'd1,        {32'h0, 32'hFFFFFFFF},        33, 1'b0};

    rst = 1'b1; start = 1'b0; signed_div = 1'b0; opdata1 = '0; opdata2 = '0; annul = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_ready", {63'b0, ready}, 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_stallreq", {63'b0, stallreq}, 64'd0);

    for (int i = 0; i < 8; i++) begin
      launch(tbl[i].sgn, tbl[i].a, tbl[i].b);
      sb_q.push_back(tbl[i].exp);
      wait_done(tbl[i].lat, tbl[i].hold);
    end

    for (int i = 0; i < 4; i++) begin
      logic sgn;
      logic [W-1:0] a;
      logic [W-1:0] b;
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = (i < 2) ? W'($urandom_range(1, 1000)) : $urandom;
      if (b == 0) b = 32'd3;
      launch(sgn, a, b);
      sb_q.push_back(model(sgn, a, b));
      wait_done(33, 1'b0);
    end

    // annul raised in cycle 10 abandons the divide
    launch(1'b1, 32'h1234, 32'd5);
    repeat (10) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    check("annul_ready", {63'b0, ready}, 64'd0);
    check("annul_stallreq", {63'b0, stallreq}, 64'd0);
    start = 1'b0;
    annul = 1'b0;
    saw_ready = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready !== 1'b0 || stallreq !== 1'b0) saw_ready = 1'b1;
    end
    check("annul_no_result", {63'b0, saw_ready}, 64'd0);
    launch(1'b0, 32'd100, 32'd7);
    sb_q.push_back({32'h2, 32'hE});
    wait_done(33, 1'b0);

    // reset pulsed in cycle 15 with start held; the divide restarts from IDLE
    launch(1'b0, 32'd1000, 32'd7);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    opdata1 = 32'd9;
    opdata2 = 32'd3;
    @(negedge clk);
    check("rst_ready", {63'b0, ready}, 64'd0);
    check("rst_result", result, 64'd0);
    rst = 1'b0;
    sb_q.push_back({32'h0, 32'h3});
    wait_done(33, 1'b0);

    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
